// File: rtl/encrypt_arb.sv
// Two-channel round-robin burst sequencer in front of one shared encrypt_unit.
// Each byte sent into the unit carries a {channel,last} tag so its output can be attributed.
module encrypt_arb #(
  parameter int TAG_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_v,
  input  logic [7:0] req_d0,
  input  logic [7:0] req_d1,
  input  logic [1:0] req_last,
  output logic [1:0] req_rdy,
  input  logic       cfg_we,
  input  logic       cfg_ch,
  input  logic [7:0] cfg_k1,
  input  logic [7:0] cfg_k2,
  input  logic [7:0] cfg_k3,
  input  logic [2:0] cfg_rot_freq,
  input  logic       cfg_shift_en,
  input  logic [2:0] cfg_shift_amt,
  input  logic       cfg_mode,
  output logic [7:0] enc_din,
  output logic       enc_en,
  output logic       enc_ctx_rst,
  output logic [7:0] enc_k1,
  output logic [7:0] enc_k2,
  output logic [7:0] enc_k3,
  output logic [2:0] enc_rot_freq,
  output logic       enc_shift_en,
  output logic [2:0] enc_shift_amt,
  output logic       enc_mode,
  input  logic [7:0] enc_dout,
  input  logic       enc_v,
  output logic [7:0] out_d,
  output logic       out_v,
  output logic       out_ch,
  output logic       out_last,
  output logic       err
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, BURST = 2'd2, DRAIN = 2'd3} state_t;

  typedef struct packed {
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] k3;
    logic [2:0] rot_freq;
    logic       shift_en;
    logic [2:0] shift_amt;
    logic       mode;
  } cfg_t;

  localparam cfg_t CFG_ZERO = cfg_t'(32'd0);

  state_t          state;
  logic            gnt;
  logic            prio;
  cfg_t            cfg_reg [2];
  cfg_t            act;
  logic [1:0]      tag_mem [TAG_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            acc_v;
  logic            acc_last;
  logic [7:0]      acc_d;
  logic            pop;
  logic            pick;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(TAG_DEPTH - 1)) begin
      ptr_inc = {PW{1'b0}};
    end else begin
      ptr_inc = p + PW'(1);
    end
  endfunction

  assign enc_k1        = act.k1;
  assign enc_k2        = act.k2;
  assign enc_k3        = act.k3;
  assign enc_rot_freq  = act.rot_freq;
  assign enc_shift_en  = act.shift_en;
  assign enc_shift_amt = act.shift_amt;
  assign enc_mode      = act.mode;

  assign fifo_full  = (count == CW'(TAG_DEPTH));
  assign fifo_empty = (count == {CW{1'b0}});
  assign acc_v      = |(req_v & req_rdy);
  assign acc_d      = gnt ? req_d1 : req_d0;
  assign acc_last   = req_last[gnt];
  assign pop        = enc_v && !fifo_empty;
  assign pick       = req_v[prio] ? prio : ~prio;

  // Only the granted channel may push, and only while a tag slot is free.
  always_comb begin
    req_rdy = 2'b00;
    if (state == BURST && !fifo_full) begin
      req_rdy[gnt] = 1'b1;
    end else begin
      req_rdy = 2'b00;
    end
  end

  // Arbitration FSM, config storage and the ingress register towards the unit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      prio        <= 1'b0;
      cfg_reg[0]  <= CFG_ZERO;
      cfg_reg[1]  <= CFG_ZERO;
      act         <= CFG_ZERO;
      enc_din     <= 8'h00;
      enc_en      <= 1'b0;
      enc_ctx_rst <= 1'b0;
    end else begin
      if (cfg_we) begin
        cfg_reg[cfg_ch] <= {cfg_k1, cfg_k2, cfg_k3, cfg_rot_freq,
                            cfg_shift_en, cfg_shift_amt, cfg_mode};
      end
      enc_en      <= acc_v;
      enc_ctx_rst <= 1'b1;
      if (acc_v) begin
        enc_din <= acc_d;
      end
      case (state)
        IDLE: begin
          if (|req_v) begin
            // Active config is captured on grant so the unit sees the new keys while held in reset.
            gnt         <= pick;
            act         <= cfg_reg[pick];
            enc_ctx_rst <= 1'b0;
            state       <= LOAD;
          end
        end
        LOAD:  state <= BURST;
        BURST: begin
          if (acc_v && acc_last) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty && !enc_v) begin
            prio  <= ~gnt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // In-flight tag FIFO; simultaneous push and pop keep the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem[i] <= 2'b00;
      end
    end else begin
      if (acc_v) begin
        tag_mem[wr_ptr] <= {gnt, acc_last};
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({acc_v, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Egress register: an untagged unit output is still forwarded but flagged as an error.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_d    <= 8'h00;
      out_v    <= 1'b0;
      out_ch   <= 1'b0;
      out_last <= 1'b0;
      err      <= 1'b0;
    end else begin
      out_v <= enc_v;
      if (enc_v) begin
        out_d    <= enc_dout;
        out_ch   <= fifo_empty ? 1'b0 : tag_mem[rd_ptr][1];
        out_last <= fifo_empty ? 1'b0 : tag_mem[rd_ptr][0];
      end
      if (enc_v && fifo_empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_encrypt_arb.sv
// Directed bench for encrypt_arb with a small queue-based model of the encrypt_unit.
module tb_encrypt_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_v, req_last, req_rdy;
  logic [7:0] req_d0, req_d1;
  logic       cfg_we, cfg_ch, cfg_shift_en, cfg_mode;
  logic [7:0] cfg_k1, cfg_k2, cfg_k3;
  logic [2:0] cfg_rot_freq, cfg_shift_amt;
  logic [7:0] enc_din, enc_k1, enc_k2, enc_k3, enc_dout, out_d;
  logic       enc_en, enc_ctx_rst, enc_shift_en, enc_mode, enc_v;
  logic [2:0] enc_rot_freq, enc_shift_amt;
  logic       out_v, out_ch, out_last, err;

  always #5 clk = ~clk;

  encrypt_arb #(.TAG_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .req_v(req_v), .req_d0(req_d0), .req_d1(req_d1),
    .req_last(req_last), .req_rdy(req_rdy), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_k1(cfg_k1), .cfg_k2(cfg_k2), .cfg_k3(cfg_k3), .cfg_rot_freq(cfg_rot_freq),
    .cfg_shift_en(cfg_shift_en), .cfg_shift_amt(cfg_shift_amt), .cfg_mode(cfg_mode),
    .enc_din(enc_din), .enc_en(enc_en), .enc_ctx_rst(enc_ctx_rst), .enc_k1(enc_k1),
    .enc_k2(enc_k2), .enc_k3(enc_k3), .enc_rot_freq(enc_rot_freq),
    .enc_shift_en(enc_shift_en), .enc_shift_amt(enc_shift_amt), .enc_mode(enc_mode),
    .enc_dout(enc_dout), .enc_v(enc_v), .out_d(out_d), .out_v(out_v), .out_ch(out_ch),
    .out_last(out_last), .err(err)
  );

  // Unit model: output byte = din ^ active k1, released in order unless held off.
  logic       hold = 1'b0;
  logic       force_v = 1'b0;
  logic [7:0] umem [64];
  logic [5:0] hd = 6'd0;
  logic [5:0] tl = 6'd0;
  assign enc_v    = force_v | (!hold && (hd != tl));
  assign enc_dout = force_v ? 8'hEE : umem[hd];
  always @(posedge clk) begin
    if (!enc_ctx_rst) begin
      hd <= tl;
    end else begin
      if (enc_v && !force_v) hd <= hd + 6'd1;
      if (enc_en) begin
        umem[tl] <= enc_din ^ enc_k1;
        tl <= tl + 6'd1;
      end
    end
  end

  logic [9:0] capq [$];
  always @(negedge clk) if (out_v) capq.push_back({out_ch, out_last, out_d});

  int nvec = 0;
  int nerr = 0;
  logic [7:0] seen_k1 [2], seen_k2 [2], seen_k3 [2];
  logic [6:0] seen_misc [2];
  logic       seen_mode [2];
  int a0, a1, fst, pls;

  typedef struct {
    int         ch;
    int         len;
    logic [7:0] base;
    logic [7:0] k1, k2, k3;
    logic [6:0] misc;
    logic       mode;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_wr(input logic ch, input logic [7:0] k1, input logic [7:0] k2,
                        input logic [7:0] k3, input logic [2:0] rf, input logic se,
                        input logic [2:0] sa, input logic md);
    cfg_ch = ch; cfg_k1 = k1; cfg_k2 = k2; cfg_k3 = k3;
    cfg_rot_freq = rf; cfg_shift_en = se; cfg_shift_amt = sa; cfg_mode = md;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Drives both channels' bursts; records grant order, LOAD pulses and keys after each LOAD.
  task automatic run(input int len0, input int len1, input int s0, input int s1,
                     input logic [7:0] b0, input logic [7:0] b1, input int maxc,
                     input int wr_at, output int acc0, output int acc1,
                     output int first, output int pulses);
    int t;
    bit was_load;
    int c;
    t = 0; was_load = 1'b0; acc0 = s0; acc1 = s1; first = -1; pulses = 0;
    while ((acc0 < len0 || acc1 < len1) && t < maxc) begin
      req_v    = {(acc1 < len1), (acc0 < len0)};
      req_d0   = b0 + 8'(acc0);
      req_d1   = b1 + 8'(acc1);
      req_last = {(acc1 == len1 - 1), (acc0 == len0 - 1)};
      cfg_we   = (t == wr_at);
      #1;
      if (was_load) begin
        chk("rdy_after_load", {31'd0, |req_rdy}, 32'd1);
        c = req_rdy[1] ? 1 : 0;
        seen_k1[c] = enc_k1; seen_k2[c] = enc_k2; seen_k3[c] = enc_k3;
        seen_misc[c] = {enc_rot_freq, enc_shift_en, enc_shift_amt};
        seen_mode[c] = enc_mode;
      end
      was_load = !enc_ctx_rst;
      if (was_load) pulses++;
      if (req_v[0] && req_rdy[0]) begin
        if (first < 0) first = 0;
        acc0++;
      end
      if (req_v[1] && req_rdy[1]) begin
        if (first < 0) first = 1;
        acc1++;
      end
      @(negedge clk);
      t++;
    end
    req_v = 2'b00; req_last = 2'b00; cfg_we = 1'b0;
  endtask

  task automatic check_out(input int ch, input int len, input logic [7:0] base,
                           input logic [7:0] key);
    int t;
    logic [9:0] e;
    t = 0;
    while (capq.size() < len && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("out_count", {31'd0, capq.size() >= len}, 32'd1);
    for (int i = 0; i < len; i++) begin
      if (capq.size() == 0) break;
      e = capq.pop_front();
      chk("out_ch", {31'd0, e[9]}, ch);
      chk("out_last", {31'd0, e[8]}, {31'd0, i == len - 1});
      chk("out_d", {24'd0, e[7:0]}, {24'd0, (base + 8'(i)) ^ key});
    end
  endtask

  initial begin
    tbl[0] = '{0, 3, 8'hA0, 8'h11, 8'h22, 8'h33, {3'd3, 1'b1, 3'd2}, 1'b1};
    tbl[1] = '{1, 4, 8'hB0, 8'h44, 8'h55, 8'h66, {3'd5, 1'b0, 3'd7}, 1'b0};
    tbl[2] = '{0, 1, 8'hC0, 8'h11, 8'h22, 8'h33, {3'd3, 1'b1, 3'd2}, 1'b1};
    tbl[3] = '{1, 2, 8'hD0, 8'h44, 8'h55, 8'h66, {3'd5, 1'b0, 3'd7}, 1'b0};

    rst = 1'b0; req_v = 2'b00; req_last = 2'b00; req_d0 = 8'h00; req_d1 = 8'h00;
    cfg_we = 1'b0; cfg_ch = 1'b0; cfg_k1 = 8'h00; cfg_k2 = 8'h00; cfg_k3 = 8'h00;
    cfg_rot_freq = 3'd0; cfg_shift_en = 1'b0; cfg_shift_amt = 3'd0; cfg_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", {30'd0, req_rdy}, 32'd0);
    chk("rst_out_v", {31'd0, out_v}, 32'd0);
    chk("rst_enc_en", {31'd0, enc_en}, 32'd0);
    chk("rst_ctx_rst", {31'd0, enc_ctx_rst}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_k1", {24'd0, enc_k1}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ctx_rst", {31'd0, enc_ctx_rst}, 32'd1);

    cfg_wr(1'b0, 8'h11, 8'h22, 8'h33, 3'd3, 1'b1, 3'd2, 1'b1);
    cfg_wr(1'b1, 8'h44, 8'h55, 8'h66, 3'd5, 1'b0, 3'd7, 1'b0);

    // Simultaneous requests right after reset: ch0, ch1, then ch0 again.
    run(2, 2, 0, 0, 8'h10, 8'h20, 200, -1, a0, a1, fst, pls);
    chk("dual_first", fst, 32'd0);
    chk("dual_pulses", pls, 32'd2);
    chk("dual_acc", a0 + a1, 32'd4);
    check_out(0, 2, 8'h10, 8'h11);
    check_out(1, 2, 8'h20, 8'h44);
    run(1, 1, 0, 0, 8'h30, 8'h40, 200, -1, a0, a1, fst, pls);
    chk("third_arb_first", fst, 32'd0);
    chk("third_arb_pulses", pls, 32'd2);
    check_out(0, 1, 8'h30, 8'h11);
    check_out(1, 1, 8'h40, 8'h44);

    for (int v = 0; v < 4; v++) begin
      run(tbl[v].ch == 0 ? tbl[v].len : 0, tbl[v].ch == 1 ? tbl[v].len : 0, 0, 0,
          tbl[v].base, tbl[v].base, 100, -1, a0, a1, fst, pls);
      chk("vec_acc", tbl[v].ch == 0 ? a0 : a1, tbl[v].len);
      chk("vec_pulses", pls, 32'd1);
      chk("vec_k1", {24'd0, seen_k1[tbl[v].ch]}, {24'd0, tbl[v].k1});
      chk("vec_k2", {24'd0, seen_k2[tbl[v].ch]}, {24'd0, tbl[v].k2});
      chk("vec_k3", {24'd0, seen_k3[tbl[v].ch]}, {24'd0, tbl[v].k3});
      chk("vec_misc", {25'd0, seen_misc[tbl[v].ch]}, {25'd0, tbl[v].misc});
      chk("vec_mode", {31'd0, seen_mode[tbl[v].ch]}, {31'd0, tbl[v].mode});
      check_out(tbl[v].ch, tbl[v].len, tbl[v].base, tbl[v].k1);
    end

    // Config write to ch0 mid-burst only takes effect at the next ch0 LOAD.
    cfg_ch = 1'b0; cfg_k1 = 8'hAA; cfg_k2 = 8'h22; cfg_k3 = 8'h33;
    cfg_rot_freq = 3'd3; cfg_shift_en = 1'b1; cfg_shift_amt = 3'd2; cfg_mode = 1'b1;
    run(4, 0, 0, 0, 8'hE0, 8'h00, 100, 3, a0, a1, fst, pls);
    chk("mid_acc", a0, 32'd4);
    chk("mid_k1_load", {24'd0, seen_k1[0]}, 32'h11);
    chk("mid_k1_held", {24'd0, enc_k1}, 32'h11);
    check_out(0, 4, 8'hE0, 8'h11);
    run(1, 0, 0, 0, 8'hF0, 8'h00, 100, -1, a0, a1, fst, pls);
    chk("next_k1_load", {24'd0, seen_k1[0]}, 32'hAA);
    check_out(0, 1, 8'hF0, 8'hAA);

    // Unit output held off: tag FIFO fills at 8, then all 12 bytes drain in order.
    hold = 1'b1;
    run(0, 12, 0, 0, 8'h00, 8'h30, 30, -1, a0, a1, fst, pls);
    chk("full_acc", a1, 32'd8);
    chk("full_rdy", {30'd0, req_rdy}, 32'd0);
    hold = 1'b0;
    run(0, 12, 0, 8, 8'h00, 8'h30, 100, -1, a0, a1, fst, pls);
    chk("full_acc_all", a1, 32'd12);
    check_out(1, 12, 8'h30, 8'h44);

    // Untagged unit output in IDLE.
    repeat (3) @(negedge clk);
    force_v = 1'b1;
    @(negedge clk);
    force_v = 1'b0;
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_out_v", {31'd0, out_v}, 32'd1);
    chk("err_out_ch", {31'd0, out_ch}, 32'd0);
    chk("err_out_last", {31'd0, out_last}, 32'd0);
    chk("err_out_d", {24'd0, out_d}, 32'hEE);
    repeat (4) @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);
    capq.delete();

    // One-cycle reset in the middle of a held-off burst.
    hold = 1'b1;
    run(0, 6, 0, 0, 8'h00, 8'h60, 5, -1, a0, a1, fst, pls);
    chk("mrst_acc", a1, 32'd3);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_rdy", {30'd0, req_rdy}, 32'd0);
    chk("mrst_out_v", {31'd0, out_v}, 32'd0);
    chk("mrst_enc_en", {31'd0, enc_en}, 32'd0);
    chk("mrst_ctx_rst", {31'd0, enc_ctx_rst}, 32'd0);
    chk("mrst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("mrst_idle_rdy", {30'd0, req_rdy}, 32'd0);
    chk("mrst_no_out", capq.size(), 32'd0);
    cfg_wr(1'b0, 8'h11, 8'h22, 8'h33, 3'd3, 1'b1, 3'd2, 1'b1);
    cfg_wr(1'b1, 8'h44, 8'h55, 8'h66, 3'd5, 1'b0, 3'd7, 1'b0);
    run(2, 0, 0, 0, 8'h70, 8'h00, 100, -1, a0, a1, fst, pls);
    chk("post_acc", a0, 32'd2);
    chk("post_k1", {24'd0, seen_k1[0]}, 32'h11);
    check_out(0, 2, 8'h70, 8'h11);
    repeat (5) @(negedge clk);
    chk("post_no_extra", capq.size(), 32'd0);
    chk("post_err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
